// File: rtl/wallace_mult_arbiter.sv
// Round-robin front end sharing one combinational multiplier between two requesters; product returned tagged with requester id.
// Latency: rsp_valid LATENCY+1 cycles after the handshake. Backpressure: a stalled response holds the block busy; new requests wait.
module wallace_mult_arbiter #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_p,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_p,
    output logic               rsp_id,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // LATENCY is limited to 1..15 so the settle count fits in four bits.
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic       last_grant;
    logic       grant_vld;
    logic       grant_id;

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (state == IDLE && rst_n) begin
            if (req0_valid && req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = ~last_grant;
            end else if (req0_valid) begin
                grant_vld = 1'b1;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign req0_ready = grant_vld && !grant_id;
    assign req1_ready = grant_vld && grant_id;
    assign busy       = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_vld) state_next = WAIT;
            WAIT:    if (cnt == 4'd0) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a      <= '0;
            mul_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_p      <= '0;
            rsp_id     <= 1'b0;
            cnt        <= 4'd0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        mul_a      <= grant_id ? req1_a : req0_a;
                        mul_b      <= grant_id ? req1_b : req0_b;
                        rsp_id     <= grant_id;
                        last_grant <= grant_id;
                        cnt        <= CNT_INIT;
                    end
                end
                WAIT: begin
                    // Operands stay frozen; mul_p is only sampled once the settle window expires.
                    if (cnt == 4'd0) begin
                        rsp_p     <= mul_p;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
